simon_key_sched_stream: RTL and testbench
=========================================

Name: simon_key_sched_stream

Overview:
- Sequential, parametrised SIMON key-schedule engine for all legal (N, M) word/key-size pairs.
- Loads an N*M-bit master key with a valid/ready handshake and streams all T round keys, one per cycle, with valid/ready backpressure.
- Stores every emitted round key in an internal RAM with a registered random-access read port, so the decrypt datapath can fetch keys in reverse order.
- Sits between the key-load interface and the round datapath; supersedes the combinational single-step key_expansion.

Parameters:
- N, 32, word size in bits; legal values 16/24/32/48/64.
- M, 4, master-key words; legal pairs are those with a defined T. An illegal pair is an elaboration $error.
- T, derived (not overridable), round count: 16→32; 24→36; 32→42/44 (M=3/4); 48→52/54 (M=2/3); 64→68/69/72 (M=2/3/4).
- Z index, derived: N=16,24→z0/z0|z1 per SIMON spec; 32: M3→z2, M4→z3; 48: M2→z2, M3→z3; 64: M2→z2, M3→z3, M4→z4.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- key_in  in  N*M  master key; word j = key_in[(j+1)*N-1 -: N] = k[j]
- key_valid  in  1  key offered
- key_ready  out  1  high in IDLE and DONE
- rk_out  out  N  current round key k[rk_idx]
- rk_idx  out  8  index of rk_out, 0..T-1
- rk_valid  out  1  rk_out/rk_idx valid
- rk_ready  in  1  consumer accepts
- rk_last  out  1  rk_valid && rk_idx==T-1
- done  out  1  sticky; set after last key accepted
- rd_addr  in  8  RAM read address
- rd_data  out  N  registered RAM data

Behaviour:
- Reset values (async, immediate): state=IDLE, rk_valid=0, rk_idx=0, rk_out=0, rk_last=0, done=0, rd_data=0; key_ready=1 (state-decoded). RAM contents undefined after reset.
- States:
  - IDLE: key_ready=1.
  - GEN: key_ready=0, rk_valid=1.
  - DONE: key_ready=1, done=1.
- Load (key_valid&&key_ready in IDLE or DONE):
  - Window w[0..M-1] ← k[0..M-1]; i←0; done←0; →GEN.
  - rk_valid rises the next cycle with rk_idx=0 and rk_out=k[0].
- GEN:
  - rk_out=w[0], rk_idx=i.
  - On rk_valid&&rk_ready: RAM[i]←w[0]; window shifts down by one; w[M-1]←knew; i←i+1.
  - knew = ~w[0] ^ t ^ (t>>>1) ^ z[(i) mod 62] ^ 3.
  - t = (w[M-1]>>>3) ^ (M==4 ? w[1] : 0). Rotations are right rotations modulo N; constant 3 is zero-extended.
  - Throughput is one key per cycle. Keys emitted in order 0..T-1; the first M keys are the master-key words.
- Stall: rk_valid&&!rk_ready holds rk_out/rk_idx/window stable, with no RAM write.
- Last: handshake at i==T-1 → DONE. That cycle rk_valid falls and done rises.
- key_valid during GEN is ignored; the key is not latched.
- Read port: rd_data ← RAM[rd_addr] each cycle, 1-cycle latency. rd_addr≥T → 0. A same-cycle write and read to the same address returns old data (read-first).
- Reset mid-GEN: everything returns to reset values at once. No partial key is retained.
- Arithmetic: all words N bits; the z table is a 5×62-bit constant ROM; i is 8 bits, no wrap (T≤72).

Test Plan:
- N=32, M=4, key 128'h19181110090801001918111009080100, rk_ready=1 → idx0..3 = 09080100, 19181110, 09080100, 19181110; idx4 = e1d16456, idx5 = 594cd5a2; 44 keys total; rk_last on idx43; done the next cycle.
- Key 128'hFEDCBA9876543210FEDCBA9876543210 with rk_ready random 50% → idx4..9 = 982f76c3, 06da77c9, b8afc3bd, 39848c8b, 36cf1c4a, 7868b81b. rk_out/rk_idx must stay stable on every stalled cycle; no duplicated or skipped index.
- Key 128'hCAFEBABEDEADBEEFFEDCBA9876543210 → idx4 = 3de916c5, idx43 = 53598864 with rk_last. After done: rd_addr=10 → rd_data = 1c617e0e one cycle later; rd_addr=44 → 0.
- Assert rst while rk_idx=20 → rk_valid=0 and done=0 immediately, key_ready=1. Reloading the scenario-1 key reproduces the identical stream.
- Pulse key_valid with a different key during GEN → ignored; stream unchanged. A new load in DONE clears done and restarts at idx0 with the new key.
- Parameter sweep (16,4), (48,3), (64,2), (64,4) against the golden software model → exactly T keys, all matching; rk_last on idx T-1.

Source files
------------

// File: rtl/simon_key_sched_stream_if.sv
// rtl/simon_key_sched_stream_if.sv - key-load, round-key stream and RAM read bundle for the SIMON key scheduler
// Purpose: groups the handshake and bus signals of simon_key_sched_stream.
// Signals:
//   key_in/key_valid/key_ready     master-key load handshake (word j = key_in[(j+1)*N-1 -: N])
//   rk_out/rk_idx/rk_valid/rk_ready/rk_last  round-key stream with backpressure
//   done                           sticky completion flag
//   rd_addr/rd_data                registered random-access read of stored round keys
// Modports: slave = key scheduler, master = key loader / round datapath.
interface simon_key_sched_stream_if #(
  parameter int N = 32,
  parameter int M = 4
);
  logic [N*M-1:0] key_in;
  logic           key_valid;
  logic           key_ready;
  logic [N-1:0]   rk_out;
  logic [7:0]     rk_idx;
  logic           rk_valid;
  logic           rk_ready;
  logic           rk_last;
  logic           done;
  logic [7:0]     rd_addr;
  logic [N-1:0]   rd_data;

  modport slave (
    input  key_in, key_valid, rk_ready, rd_addr,
    output key_ready, rk_out, rk_idx, rk_valid, rk_last, done, rd_data
  );

  modport master (
    output key_in, key_valid, rk_ready, rd_addr,
    input  key_ready, rk_out, rk_idx, rk_valid, rk_last, done, rd_data
  );
endinterface

// File: rtl/simon_key_sched_stream.sv
// rtl/simon_key_sched_stream.sv - sequential SIMON key-schedule engine streaming all round keys
// Purpose: loads an N*M-bit master key, streams the T round keys one per cycle with
//   valid/ready backpressure and stores each accepted key in a RAM for reverse-order fetch.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  simon_key_sched_stream_if slave modport (key load, round-key stream, RAM read)
module simon_key_sched_stream #(
  parameter int N = 32,
  parameter int M = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  simon_key_sched_stream_if.slave bus
);

  function automatic int calc_t(input int n, input int m);
    if (n == 16 && m == 4) return 32;
    if (n == 24 && (m == 3 || m == 4)) return 36;
    if (n == 32 && m == 3) return 42;
    if (n == 32 && m == 4) return 44;
    if (n == 48 && m == 2) return 52;
    if (n == 48 && m == 3) return 54;
    if (n == 64 && m == 2) return 68;
    if (n == 64 && m == 3) return 69;
    if (n == 64 && m == 4) return 72;
    return 0;
  endfunction

  function automatic int calc_z(input int n, input int m);
    if (n == 16) return 0;
    if (n == 24) return (m == 4) ? 1 : 0;
    if (n == 32) return (m == 4) ? 3 : 2;
    if (n == 48) return (m == 3) ? 3 : 2;
    if (n == 64) return m;
    return 0;
  endfunction

  localparam int T    = calc_t(N, M);
  localparam int TS   = (T > 0) ? T : 1;
  localparam int AW   = (TS > 2) ? $clog2(TS) : 1;
  localparam int ZSEL = calc_z(N, M);
  localparam logic [7:0] T8     = 8'(T);
  localparam logic [7:0] LAST   = 8'(T - 1);
  localparam logic [7:0] PENULT = 8'(T - 2);

  if (T == 0) begin : g_illegal
    $error("simon_key_sched_stream: unsupported (N, M) pair");
  end

  // Constant sequences z0..z4; the leftmost character (bit 61) is z[0].
  localparam logic [61:0] Z_ROM [5] = '{
    62'b11111010001001010110000111001101111101000100101011000011100110,
    62'b10001110111110010011000010110101000111011111001001100001011010,
    62'b10101111011100000011010010011000101000010001111110010110110011,
    62'b11011011101011000110010111100000010010001010011100110100001111,
    62'b11010001111001101011011000100000010111000011001010010011101111
  };

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_DONE} state_t;

  state_t       state;
  logic [N-1:0] win [M];      // sliding window k[i..i+M-1]; win[0] is the key being offered
  logic [7:0]   idx;
  logic         rk_valid_q;
  logic         rk_last_q;
  logic         done_q;
  logic [N-1:0] rd_data_q;
  logic [N-1:0] ram [TS];

  logic [N-1:0] t;
  logic [N-1:0] knew;
  logic [7:0]   zi;
  logic [5:0]   zpos;
  logic         zbit;
  logic         fire;

  // Next schedule word k[i+M] from the current window.
  always_comb begin
    zi   = (idx >= 8'd62) ? idx - 8'd62 : idx;
    zpos = 6'(8'd61 - zi);
    zbit = Z_ROM[ZSEL][zpos];
    t    = {win[M-1][2:0], win[M-1][N-1:3]} ^ ((M == 4) ? win[1] : '0);
    knew = ~win[0] ^ t ^ {t[0], t[N-1:1]} ^ {{(N-1){1'b0}}, zbit} ^ N'(3);
  end

  // In GEN rk_valid is always high, so rk_ready alone completes the handshake.
  assign fire = (state == S_GEN) && bus.rk_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      rk_valid_q <= 1'b0;
      rk_last_q  <= 1'b0;
      done_q     <= 1'b0;
      for (int j = 0; j < M; j++) win[j] <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.key_valid) begin
            for (int j = 0; j < M; j++) win[j] <= bus.key_in[j*N +: N];
            idx        <= '0;
            rk_valid_q <= 1'b1;
            rk_last_q  <= 1'b0;
            done_q     <= 1'b0;
            state      <= S_GEN;
          end
        end
        S_GEN: begin
          if (bus.rk_ready) begin
            for (int j = 0; j < M - 1; j++) win[j] <= win[j+1];
            win[M-1] <= knew;
            idx      <= idx + 8'd1;
            if (idx == LAST) begin
              state      <= S_DONE;
              rk_valid_q <= 1'b0;
              rk_last_q  <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              rk_last_q <= (idx == PENULT);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Round-key store; no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (fire) ram[idx[AW-1:0]] <= win[0];
  end

  // Registered read; a same-cycle write to the same address is not visible (read-first).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (bus.rd_addr < T8) begin
      rd_data_q <= ram[bus.rd_addr[AW-1:0]];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign bus.key_ready = (state != S_GEN);
  assign bus.rk_out    = win[0];
  assign bus.rk_idx    = idx;
  assign bus.rk_valid  = rk_valid_q;
  assign bus.rk_last   = rk_last_q;
  assign bus.done      = done_q;
  assign bus.rd_data   = rd_data_q;

endmodule

// File: tb/tb_simon_key_sched_stream.sv
// tb/tb_simon_key_sched_stream.sv - scoreboard testbench for simon_key_sched_stream
module tb_simon_key_sched_stream;

  localparam int TM = 44;
  localparam logic [127:0] K1 = 128'h19181110090801001918111009080100;
  localparam logic [127:0] K2 = 128'hFEDCBA9876543210FEDCBA9876543210;
  localparam logic [127:0] K3 = 128'hCAFEBABEDEADBEEFFEDCBA9876543210;

  localparam int SW_N [4] = '{16, 48, 64, 64};
  localparam int SW_M [4] = '{4, 3, 2, 4};
  localparam int SW_T [4] = '{32, 54, 68, 72};
  localparam logic [255:0] SW_KEY =
    256'h1f1e1d1c_1b1a1918_17161514_13121110_0f0e0d0c_0b0a0908_07060504_03020100;

  logic clk;
  logic rst;
  logic rst_s;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [71:0] exp_q [$];
  logic [31:0] got [72];

  simon_key_sched_stream_if #(.N(32), .M(4)) if0 ();
  simon_key_sched_stream #(.N(32), .M(4)) dut (.clk(clk), .rst(rst), .bus(if0.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic note_fail(input string nm, input logic [63:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %h with nothing expected", nm, act);
  endtask

  function automatic logic [61:0] z_seq(input int s);
    case (s)
      0: return 62'b11111010001001010110000111001101111101000100101011000011100110;
      1: return 62'b10001110111110010011000010110101000111011111001001100001011010;
      2: return 62'b10101111011100000011010010011000101000010001111110010110110011;
      3: return 62'b11011011101011000110010111100000010010001010011100110100001111;
      default: return 62'b11010001111001101011011000100000010111000011001010010011101111;
    endcase
  endfunction

  function automatic int z_index(input int n, input int m);
    case (n)
      16: return 0;
      24: return (m == 3) ? 0 : 1;
      32: return (m == 3) ? 2 : 3;
      48: return (m == 2) ? 2 : 3;
      default: return (m == 2) ? 2 : ((m == 3) ? 3 : 4);
    endcase
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x, input int s, input int n);
    logic [63:0] mask;
    logic [63:0] v;
    mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    v = x & mask;
    return ((v >> s) | (v << (n - s))) & mask;
  endfunction

  // Reference schedule in array form: k[i] built from k[i-m..i-1].
  function automatic logic [63:0] model_rk(input int n, input int m, input logic [255:0] key, input int idx);
    logic [63:0]  k [72];
    logic [63:0]  mask;
    logic [63:0]  t;
    logic [63:0]  zc;
    logic [255:0] sh;
    logic [61:0]  zs;
    mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    zs = z_seq(z_index(n, m));
    for (int j = 0; j < 72; j++) k[j] = '0;
    for (int j = 0; j < m; j++) begin
      sh = key >> (j * n);
      k[j] = sh[63:0] & mask;
    end
    for (int i = m; i <= idx; i++) begin
      t = rotr(k[i-1], 3, n);
      if (m == 4) t = t ^ k[i-3];
      t = t ^ rotr(t, 1, n);
      zc = {63'd0, zs[61 - ((i - m) % 62)]};
      k[i] = (~k[i-m] ^ t ^ zc ^ 64'd3) & mask;
    end
    return k[idx];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_stream(input logic [127:0] k);
    for (int i = 0; i < TM; i++) exp_q.push_back({8'(i), model_rk(32, 4, {128'd0, k}, i)});
  endtask

  task automatic load_key(input logic [127:0] k);
    push_stream(k);
    if0.key_in    = k;
    if0.key_valid = 1'b1;
    tick();
    if0.key_valid = 1'b0;
  endtask

  task automatic run_to_done(input bit rnd);
    int cyc = 0;
    while (!if0.done && cyc < 2000) begin
      if (rnd) if0.rk_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    if0.rk_ready = 1'b1;
    check("done_reached", 64'(if0.done), 64'd1);
    check("stream_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic rd_check(input logic [7:0] a, input logic [31:0] exp);
    if0.rd_addr = a;
    tick();
    check($sformatf("rd_data[%0d]", a), 64'(if0.rd_data), 64'(exp));
  endtask

  // Stream monitor: every valid cycle must present the head of the scoreboard,
  // which also proves stability across stalls.
  logic chk_done = 1'b0;
  always @(negedge clk) begin
    logic [71:0] e;
    if (rst) begin
      chk_done = 1'b0;
    end else begin
      if (chk_done) begin
        check("done_after_last", 64'(if0.done), 64'd1);
        check("valid_after_last", 64'(if0.rk_valid), 64'd0);
        chk_done = 1'b0;
      end
      if (if0.rk_valid) begin
        if (exp_q.size() == 0) begin
          if (if0.rk_ready) note_fail("unexpected_key", 64'(if0.rk_idx));
        end else begin
          e = exp_q[0];
          check("rk_idx", 64'(if0.rk_idx), 64'(e[71:64]));
          check("rk_out", 64'(if0.rk_out), e[63:0]);
          check("rk_last", 64'(if0.rk_last), 64'(e[71:64] == 8'(TM - 1)));
          if (if0.rk_ready) begin
            void'(exp_q.pop_front());
            if (if0.rk_idx < 8'd72) got[if0.rk_idx] = if0.rk_out;
            if (if0.rk_last) chk_done = 1'b1;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int GN = SW_N[g];
    localparam int GM = SW_M[g];
    localparam int GT = SW_T[g];

    simon_key_sched_stream_if #(.N(GN), .M(GM)) sif ();
    simon_key_sched_stream #(.N(GN), .M(GM)) sdut (.clk(clk), .rst(rst_s), .bus(sif.slave));

    logic [63:0] sq [$];
    int   scnt = 0;
    logic fin  = 1'b0;

    initial begin
      sif.key_in    = SW_KEY[GN*GM-1:0];
      sif.key_valid = 1'b0;
      sif.rk_ready  = 1'b1;
      sif.rd_addr   = '0;
      wait (rst_s == 1'b1);
      wait (rst_s == 1'b0);
      @(posedge clk);
      #1;
      for (int i = 0; i < GT; i++) sq.push_back(model_rk(GN, GM, SW_KEY, i));
      sif.key_valid = 1'b1;
      @(posedge clk);
      #1;
      sif.key_valid = 1'b0;
      for (int c = 0; c < 500 && !sif.done; c++) begin
        @(posedge clk);
        #1;
      end
      check($sformatf("sweep%0d_done", g), 64'(sif.done), 64'd1);
      check($sformatf("sweep%0d_count", g), 64'(scnt), 64'(GT));
      fin = 1'b1;
    end

    always @(negedge clk) begin
      if (!rst_s && sif.rk_valid && sif.rk_ready) begin
        if (sq.size() == 0) begin
          note_fail($sformatf("sweep%0d_extra", g), 64'(sif.rk_idx));
        end else begin
          check($sformatf("sweep%0d_idx", g), 64'(sif.rk_idx), 64'(scnt));
          check($sformatf("sweep%0d_rk", g), 64'(sif.rk_out), sq.pop_front());
          check($sformatf("sweep%0d_last", g), 64'(sif.rk_last), 64'(scnt == GT - 1));
        end
        scnt++;
      end
    end
  end

  initial begin
    int cyc;
    rst   = 1'b0;
    rst_s = 1'b0;
    if0.key_in    = '0;
    if0.key_valid = 1'b0;
    if0.rk_ready  = 1'b1;
    if0.rd_addr   = '0;
    #3;
    rst   = 1'b1;
    rst_s = 1'b1;
    tick();
    tick();
    check("rst_rk_valid", 64'(if0.rk_valid), 64'd0);
    check("rst_rk_idx", 64'(if0.rk_idx), 64'd0);
    check("rst_rk_out", 64'(if0.rk_out), 64'd0);
    check("rst_rk_last", 64'(if0.rk_last), 64'd0);
    check("rst_done", 64'(if0.done), 64'd0);
    check("rst_rd_data", 64'(if0.rd_data), 64'd0);
    check("rst_key_ready", 64'(if0.key_ready), 64'd1);
    rst   = 1'b0;
    rst_s = 1'b0;
    tick();

    // Scenario 1: full-rate stream of the reference key.
    load_key(K1);
    check("s1_first_valid", 64'(if0.rk_valid), 64'd1);
    check("s1_first_out", 64'(if0.rk_out), 64'h09080100);
    check("s1_key_ready_gen", 64'(if0.key_ready), 64'd0);
    run_to_done(1'b0);
    check("s1_idx0", 64'(got[0]), 64'h09080100);
    check("s1_idx1", 64'(got[1]), 64'h19181110);
    check("s1_idx2", 64'(got[2]), 64'h09080100);
    check("s1_idx3", 64'(got[3]), 64'h19181110);
    check("s1_idx4", 64'(got[4]), 64'he1d16456);
    check("s1_idx5", 64'(got[5]), 64'h594cd5a2);
    check("s1_key_ready_done", 64'(if0.key_ready), 64'd1);

    // Scenario 2: reload from DONE with random backpressure.
    load_key(K2);
    check("s2_done_cleared", 64'(if0.done), 64'd0);
    check("s2_restart_idx", 64'(if0.rk_idx), 64'd0);
    check("s2_restart_out", 64'(if0.rk_out), 64'h76543210);
    run_to_done(1'b1);
    check("s2_idx4", 64'(got[4]), 64'h982f76c3);
    check("s2_idx5", 64'(got[5]), 64'h06da77c9);
    check("s2_idx6", 64'(got[6]), 64'hb8afc3bd);
    check("s2_idx7", 64'(got[7]), 64'h39848c8b);
    check("s2_idx8", 64'(got[8]), 64'h36cf1c4a);
    check("s2_idx9", 64'(got[9]), 64'h7868b81b);

    // Scenario 3: mixed key, then RAM read-back.
    load_key(K3);
    run_to_done(1'b0);
    check("s3_idx4", 64'(got[4]), 64'h3de916c5);
    check("s3_idx43", 64'(got[43]), 64'h53598864);
    rd_check(8'd10, 32'h1c617e0e);
    rd_check(8'd44, 32'h0);
    rd_check(8'd43, 32'h53598864);
    rd_check(8'd0, 32'h76543210);
    rd_check(8'd255, 32'h0);

    // Scenario 4: asynchronous reset in the middle of the stream.
    load_key(K1);
    cyc = 0;
    while (if0.rk_idx != 8'd20 && cyc < 200) begin
      tick();
      cyc++;
    end
    check("s4_reached_idx20", 64'(if0.rk_idx), 64'd20);
    rst = 1'b1;
    #1;
    check("s4_rst_valid", 64'(if0.rk_valid), 64'd0);
    check("s4_rst_done", 64'(if0.done), 64'd0);
    check("s4_rst_key_ready", 64'(if0.key_ready), 64'd1);
    check("s4_rst_idx", 64'(if0.rk_idx), 64'd0);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
    load_key(K1);
    run_to_done(1'b0);
    check("s4_idx4", 64'(got[4]), 64'he1d16456);
    check("s4_idx5", 64'(got[5]), 64'h594cd5a2);

    // Scenario 5: a key offered during GEN must be ignored.
    load_key(K1);
    for (int i = 0; i < 5; i++) tick();
    if0.key_in    = K3;
    if0.key_valid = 1'b1;
    tick();
    if0.key_valid = 1'b0;
    check("s5_still_gen", 64'(if0.key_ready), 64'd0);
    run_to_done(1'b0);
    check("s5_idx4", 64'(got[4]), 64'he1d16456);

    cyc = 0;
    while (!(g_sweep[0].fin && g_sweep[1].fin && g_sweep[2].fin && g_sweep[3].fin) && cyc < 2000) begin
      tick();
      cyc++;
    end
    check("sweep_finished",
          64'({g_sweep[3].fin, g_sweep[2].fin, g_sweep[1].fin, g_sweep[0].fin}), 64'hf);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
